// File: rtl/tile_map_fetcher.sv
// Tile map fetcher: turns the VGA scan position into tile / tile-local coordinates,
// looks up the 4-bit sprite code in the level map, and owns the map RAM with its clear engine.
module tile_map_fetcher #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int TILE_W   = 32,
    parameter int TILE_H   = 32,
    parameter int MAP_COLS = 20,
    parameter int MAP_ROWS = 15
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [9:0] i_Col_Count,
    input  logic [9:0] i_Row_Count,
    input  logic       i_Clear,
    input  logic       i_Wr_En,
    input  logic [4:0] i_Wr_X,
    input  logic [3:0] i_Wr_Y,
    input  logic [3:0] i_Wr_Sprite,
    output logic       o_Wr_Ack,
    output logic       o_Wr_Err,
    output logic       o_Busy,
    output logic       o_Valid,
    output logic [4:0] o_Tile_X,
    output logic [3:0] o_Tile_Y,
    output logic [4:0] o_Local_X,
    output logic [4:0] o_Local_Y,
    output logic [3:0] o_Sprite
);

    localparam int TXB       = $clog2(TILE_W);
    localparam int TYB       = $clog2(TILE_H);
    localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
    localparam logic [8:0] LAST_ADDR = 9'(MAP_DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] clr_addr_q, clr_addr_d;
    logic       busy_q, busy_d;

    logic       wr_in_range_s, wr_accept_s;
    logic [8:0] wr_addr_s;
    logic       ram_we_s;
    logic [8:0] ram_waddr_s;
    logic [3:0] ram_wdata_s;

    logic [4:0] tile_x_s, local_x_s, local_y_s;
    logic [3:0] tile_y_s;
    logic       vis_s;
    logic [8:0] rd_addr_s;

    logic [4:0] s1_tile_x_q, s1_local_x_q, s1_local_y_q;
    logic [3:0] s1_tile_y_q;
    logic       s1_vis_q;
    logic [8:0] s1_addr_q;
    logic       show_s;

    logic       ack_q, err_q, valid_q;
    logic [4:0] tile_x_q, local_x_q, local_y_q;
    logic [3:0] tile_y_q, sprite_q;

    logic [3:0] mem_q [0:MAP_DEPTH-1];

    // Clear engine sequencing: CLEAR walks every address once, RUN waits for a clear request.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    clr_addr_d = 9'd0;
                end else begin
                    clr_addr_d = clr_addr_q + 9'd1;
                end
            end
            ST_RUN: begin
                if (i_Clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = 9'd0;
                end else begin
                    clr_addr_d = 9'd0;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = 9'd0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // A clear request in the same cycle takes priority, so the write is dropped.
    always_comb begin
        wr_in_range_s = (i_Wr_X < 5'(MAP_COLS)) && (i_Wr_Y < 4'(MAP_ROWS));
        wr_accept_s   = i_Wr_En && (state_q == ST_RUN) && !i_Clear && wr_in_range_s;
        wr_addr_s     = 9'(i_Wr_Y) * 9'(MAP_COLS) + 9'(i_Wr_X);
        if (state_q == ST_CLEAR) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_addr_q;
            ram_wdata_s = 4'h0;
        end else begin
            ram_we_s    = wr_accept_s;
            ram_waddr_s = wr_addr_s;
            ram_wdata_s = i_Wr_Sprite;
        end
    end

    // Power-of-two tiles make the divide / modulo plain bit slices.
    always_comb begin
        tile_x_s  = 5'(i_Col_Count >> TXB);
        tile_y_s  = 4'(i_Row_Count >> TYB);
        local_x_s = 5'(i_Col_Count[TXB-1:0]);
        local_y_s = 5'(i_Row_Count[TYB-1:0]);
        vis_s     = (i_Col_Count < 10'(H_ACTIVE)) && (i_Row_Count < 10'(V_ACTIVE));
        if (vis_s) begin
            rd_addr_s = 9'(tile_y_s) * 9'(MAP_COLS) + 9'(tile_x_s);
        end else begin
            rd_addr_s = 9'd0;
        end
    end

    // Masking on both busy_q and busy_d keeps o_Valid low on every cycle o_Busy is high
    // and on the final clear cycle, whose last address is still being zeroed.
    assign show_s = s1_vis_q && !busy_q && !busy_d;

    // Control state and write handshake pulses.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= 9'd0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
            ack_q      <= wr_accept_s;
            err_q      <= i_Wr_En && !wr_accept_s;
        end
    end

    // Map storage has no reset; the clear engine zeroes it instead.
    always_ff @(posedge i_Clk) begin
        if (ram_we_s) begin
            mem_q[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // Stage 1: coordinate split and map address.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            s1_tile_x_q  <= 5'd0;
            s1_tile_y_q  <= 4'd0;
            s1_local_x_q <= 5'd0;
            s1_local_y_q <= 5'd0;
            s1_vis_q     <= 1'b0;
            s1_addr_q    <= 9'd0;
        end else begin
            s1_tile_x_q  <= tile_x_s;
            s1_tile_y_q  <= tile_y_s;
            s1_local_x_q <= local_x_s;
            s1_local_y_q <= local_y_s;
            s1_vis_q     <= vis_s;
            s1_addr_q    <= rd_addr_s;
        end
    end

    // Stage 2: read-first RAM read plus delayed coordinates.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            valid_q   <= 1'b0;
            sprite_q  <= 4'h0;
            tile_x_q  <= 5'd0;
            tile_y_q  <= 4'd0;
            local_x_q <= 5'd0;
            local_y_q <= 5'd0;
        end else begin
            valid_q   <= show_s;
            sprite_q  <= show_s ? mem_q[s1_addr_q] : 4'h0;
            tile_x_q  <= s1_vis_q ? s1_tile_x_q  : 5'd0;
            tile_y_q  <= s1_vis_q ? s1_tile_y_q  : 4'd0;
            local_x_q <= s1_vis_q ? s1_local_x_q : 5'd0;
            local_y_q <= s1_vis_q ? s1_local_y_q : 5'd0;
        end
    end

    assign o_Wr_Ack  = ack_q;
    assign o_Wr_Err  = err_q;
    assign o_Busy    = busy_q;
    assign o_Valid   = valid_q;
    assign o_Tile_X  = tile_x_q;
    assign o_Tile_Y  = tile_y_q;
    assign o_Local_X = local_x_q;
    assign o_Local_Y = local_y_q;
    assign o_Sprite  = sprite_q;

endmodule

// File: tb/tb_tile_map_fetcher.sv
// Scoreboard bench for tile_map_fetcher: scan results are predicted from a bench-side
// copy of the tile map when the scan is driven and compared two cycles later.
module tb_tile_map_fetcher;

    logic       clk;
    logic       rst_n;
    logic [9:0] col;
    logic [9:0] row;
    logic       clr;
    logic       wr_en;
    logic [4:0] wr_x;
    logic [3:0] wr_y;
    logic [3:0] wr_sp;
    logic       o_Wr_Ack, o_Wr_Err, o_Busy, o_Valid;
    logic [4:0] o_Tile_X, o_Local_X, o_Local_Y;
    logic [3:0] o_Tile_Y, o_Sprite;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  ref_map [0:299];
    logic [23:0] sb_q [$];
    logic [23:0] obs_s;

    assign obs_s = {o_Valid, o_Tile_X, o_Tile_Y, o_Local_X, o_Local_Y, o_Sprite};

    tile_map_fetcher dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Col_Count (col),
        .i_Row_Count (row),
        .i_Clear     (clr),
        .i_Wr_En     (wr_en),
        .i_Wr_X      (wr_x),
        .i_Wr_Y      (wr_y),
        .i_Wr_Sprite (wr_sp),
        .o_Wr_Ack    (o_Wr_Ack),
        .o_Wr_Err    (o_Wr_Err),
        .o_Busy      (o_Busy),
        .o_Valid     (o_Valid),
        .o_Tile_X    (o_Tile_X),
        .o_Tile_Y    (o_Tile_Y),
        .o_Local_X   (o_Local_X),
        .o_Local_Y   (o_Local_Y),
        .o_Sprite    (o_Sprite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] model_pixel(input int c, input int r);
        int tx;
        int ty;
        if (c < 640 && r < 480) begin
            tx = c / 32;
            ty = r / 32;
            return {1'b1, 5'(tx), 4'(ty), 5'(c % 32), 5'(r % 32), ref_map[ty * 20 + tx]};
        end
        return 24'h0;
    endfunction

    task automatic set_scan(input int c, input int r);
        col = 10'(c);
        row = 10'(r);
        sb_q.push_back(model_pixel(c, r));
    endtask

    task automatic test_reset();
        int cnt;
        int bad_valid;
        logic [23:0] exp_v;
        int sc[$];
        int sr[$];
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({o_Busy, o_Wr_Ack, o_Wr_Err, obs_s} !== {1'b1, 1'b0, 1'b0, 24'h0}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", {o_Busy, o_Wr_Ack, o_Wr_Err, obs_s}, {1'b1, 26'h0});
        end
        rst_n = 1'b1;
        repeat (100) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cnt = 0;
        bad_valid = 0;
        while (o_Busy && cnt < 400) begin
            tick();
            cnt++;
            if (o_Valid !== 1'b0 || o_Sprite !== 4'h0) bad_valid++;
        end
        checks++;
        if (cnt != 300) begin
            failures++;
            $display("FAIL busy_len_after_reset got=%0d exp=300", cnt);
        end
        checks++;
        if (bad_valid != 0) begin
            failures++;
            $display("FAIL valid_during_clear got=%0d bad cycles exp=0", bad_valid);
        end
        for (int i = 0; i < 300; i++) ref_map[i] = 4'h0;
        sc = '{0, 639, 31};
        sr = '{0, 479, 33};
        for (int i = 0; i <= sc.size(); i++) begin
            if (i < sc.size()) set_scan(sc[i], sr[i]);
            tick();
            if (i > 0) begin
                exp_v = sb_q.pop_front();
                checks++;
                if (obs_s !== exp_v) begin
                    failures++;
                    $display("FAIL post_reset_scan[%0d] got=%h exp=%h", i - 1, obs_s, exp_v);
                end
            end
        end
    endtask

    task automatic test_write_read();
        logic [23:0] exp_v;
        int sc[$];
        int sr[$];
        wr_en = 1'b1; wr_x = 5'd3; wr_y = 4'd2; wr_sp = 4'h2;
        tick();
        wr_en = 1'b0;
        ref_map[2 * 20 + 3] = 4'h2;
        checks++;
        if ({o_Wr_Ack, o_Wr_Err} !== 2'b10) begin
            failures++;
            $display("FAIL write_ack got=%b exp=10", {o_Wr_Ack, o_Wr_Err});
        end
        tick();
        checks++;
        if ({o_Wr_Ack, o_Wr_Err} !== 2'b00) begin
            failures++;
            $display("FAIL write_ack_pulse got=%b exp=00", {o_Wr_Ack, o_Wr_Err});
        end
        sc = '{100, 96, 127, 128};
        sr = '{70, 64, 95, 70};
        for (int i = 0; i <= sc.size(); i++) begin
            if (i < sc.size()) set_scan(sc[i], sr[i]);
            tick();
            if (i > 0) begin
                exp_v = sb_q.pop_front();
                checks++;
                if (obs_s !== exp_v) begin
                    failures++;
                    $display("FAIL write_read_scan[%0d] got=%h exp=%h", i - 1, obs_s, exp_v);
                end
            end
        end
    endtask

    task automatic test_write_err();
        logic [23:0] exp_v;
        int sc[$];
        int sr[$];
        int wx[$];
        int wy[$];
        wx = '{20, 0, 31};
        wy = '{0, 15, 14};
        for (int i = 0; i < wx.size(); i++) begin
            wr_en = 1'b1; wr_x = 5'(wx[i]); wr_y = 4'(wy[i]); wr_sp = 4'h5;
            tick();
            wr_en = 1'b0;
            checks++;
            if ({o_Wr_Ack, o_Wr_Err} !== 2'b01) begin
                failures++;
                $display("FAIL write_err[%0d] got=%b exp=01", i, {o_Wr_Ack, o_Wr_Err});
            end
        end
        sc = '{608, 0};
        sr = '{0, 448};
        for (int i = 0; i <= sc.size(); i++) begin
            if (i < sc.size()) set_scan(sc[i], sr[i]);
            tick();
            if (i > 0) begin
                exp_v = sb_q.pop_front();
                checks++;
                if (obs_s !== exp_v) begin
                    failures++;
                    $display("FAIL write_err_scan[%0d] got=%h exp=%h", i - 1, obs_s, exp_v);
                end
            end
        end
    endtask

    task automatic test_nonvisible();
        logic [23:0] exp_v;
        int sc[$];
        int sr[$];
        sc = '{640, 5, 799, 100};
        sr = '{10, 480, 524, 70};
        for (int i = 0; i <= sc.size(); i++) begin
            if (i < sc.size()) set_scan(sc[i], sr[i]);
            tick();
            if (i > 0) begin
                exp_v = sb_q.pop_front();
                checks++;
                if (obs_s !== exp_v) begin
                    failures++;
                    $display("FAIL nonvisible_scan[%0d] got=%h exp=%h", i - 1, obs_s, exp_v);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [23:0] exp_v;
        set_scan(40, 40);
        tick();
        wr_en = 1'b1; wr_x = 5'd1; wr_y = 4'd1; wr_sp = 4'h4;
        ref_map[1 * 20 + 1] = 4'h4;
        set_scan(41, 42);
        tick();
        wr_en = 1'b0;
        checks++;
        if (o_Wr_Ack !== 1'b1) begin
            failures++;
            $display("FAIL collision_ack got=%b exp=1", o_Wr_Ack);
        end
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_s !== exp_v) begin
            failures++;
            $display("FAIL collision_old got=%h exp=%h", obs_s, exp_v);
        end
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_s !== exp_v) begin
            failures++;
            $display("FAIL collision_new got=%h exp=%h", obs_s, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_v;
        int sc[$];
        int sr[$];
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_x = 5'(i * 2); wr_y = 4'(i % 15 + 3); wr_sp = 4'(i + 6);
            ref_map[(i % 15 + 3) * 20 + i * 2] = 4'(i + 6);
            tick();
            checks++;
            if ({o_Wr_Ack, o_Wr_Err} !== 2'b10) begin
                failures++;
                $display("FAIL b2b_ack[%0d] got=%b exp=10", i, {o_Wr_Ack, o_Wr_Err});
            end
        end
        wr_en = 1'b0;
        tick();
        checks++;
        if (o_Wr_Ack !== 1'b0) begin
            failures++;
            $display("FAIL b2b_extra_ack got=%b exp=0", o_Wr_Ack);
        end
        for (int i = 0; i < 10; i++) begin
            sc.push_back(i * 64 + i);
            sr.push_back((i % 15 + 3) * 32 + 31 - i);
        end
        for (int i = 0; i < 40; i++) begin
            sc.push_back(int'($urandom_range(799, 0)));
            sr.push_back(int'($urandom_range(524, 0)));
        end
        for (int i = 0; i <= sc.size(); i++) begin
            if (i < sc.size()) set_scan(sc[i], sr[i]);
            tick();
            if (i > 0) begin
                exp_v = sb_q.pop_front();
                checks++;
                if (obs_s !== exp_v) begin
                    failures++;
                    $display("FAIL b2b_scan[%0d] col=%0d row=%0d got=%h exp=%h",
                             i - 1, sc[i - 1], sr[i - 1], obs_s, exp_v);
                end
            end
        end
    endtask

    task automatic test_clear();
        int cnt;
        int bad_valid;
        logic [23:0] exp_v;
        col = 10'd100; row = 10'd70;
        clr = 1'b1;
        wr_en = 1'b1; wr_x = 5'd5; wr_y = 4'd5; wr_sp = 4'h7;
        tick();
        clr = 1'b0;
        wr_en = 1'b0;
        checks++;
        if ({o_Wr_Ack, o_Wr_Err, o_Busy} !== 3'b011) begin
            failures++;
            $display("FAIL clear_with_write got=%b exp=011", {o_Wr_Ack, o_Wr_Err, o_Busy});
        end
        cnt = 0;
        bad_valid = 0;
        while (o_Busy && cnt < 400) begin
            clr   = (cnt == 100);
            wr_en = (cnt == 50);
            wr_x = 5'd2; wr_y = 4'd2; wr_sp = 4'h9;
            tick();
            cnt++;
            if (o_Valid !== 1'b0 || o_Sprite !== 4'h0) bad_valid++;
            if (cnt == 51) begin
                checks++;
                if ({o_Wr_Ack, o_Wr_Err} !== 2'b01) begin
                    failures++;
                    $display("FAIL write_while_busy got=%b exp=01", {o_Wr_Ack, o_Wr_Err});
                end
            end
        end
        clr = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (cnt != 300) begin
            failures++;
            $display("FAIL busy_len_after_clear got=%0d exp=300", cnt);
        end
        checks++;
        if (bad_valid != 0) begin
            failures++;
            $display("FAIL valid_during_reclear got=%0d bad cycles exp=0", bad_valid);
        end
        for (int i = 0; i < 300; i++) ref_map[i] = 4'h0;
        for (int i = 0; i <= 300; i++) begin
            if (i < 300) set_scan((i % 20) * 32 + (i % 32), (i / 20) * 32 + ((i * 7) % 32));
            tick();
            if (i > 0) begin
                exp_v = sb_q.pop_front();
                checks++;
                if (obs_s !== exp_v) begin
                    failures++;
                    $display("FAIL cleared_tile[%0d] got=%h exp=%h", i - 1, obs_s, exp_v);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        col = 10'd0; row = 10'd0;
        clr = 1'b0; wr_en = 1'b0;
        wr_x = 5'd0; wr_y = 4'd0; wr_sp = 4'h0;
        test_reset();
        test_write_read();
        test_write_err();
        test_nonvisible();
        test_collision();
        test_back_to_back();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
